// File: rtl/mem_request_bridge.sv
// mem_request_bridge: turns one held 32-bit core request into a single-line MIG DDR3 access plus one response pulse.
// Define MEM_LINE_CACHE_EN to add a one-line read buffer that serves repeat reads without MIG traffic.
module mem_request_bridge #(
    parameter int ADDR_WIDTH     = 28,
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_MASK_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init_calib_complete,
    input  logic                      req_valid,
    input  logic                      req_wren,
    input  logic                      req_rden,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      req_ready,
    output logic                      resp_valid,
    output logic [31:0]               resp_rdata,
    output logic [ADDR_WIDTH-1:0]     app_addr,
    output logic [2:0]                app_cmd,
    output logic                      app_en,
    input  logic                      app_rdy,
    output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
    output logic [APP_MASK_WIDTH-1:0] app_wdf_mask,
    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    input  logic                      app_wdf_rdy,
    input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
    input  logic                      app_rd_data_valid
);
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [2:0] {INIT, IDLE, RD, RD_WAIT, WR, RESP} state_t;

    state_t                    state_q, state_d;
    logic                      req_ready_q, req_ready_d;
    logic                      resp_valid_q, resp_valid_d;
    logic [31:0]               resp_rdata_q, resp_rdata_d;
    logic [ADDR_WIDTH-1:0]     app_addr_q, app_addr_d;
    logic [2:0]                app_cmd_q, app_cmd_d;
    logic                      app_en_q, app_en_d;
    logic                      app_wdf_wren_q, app_wdf_wren_d;
    logic [APP_DATA_WIDTH-1:0] app_wdf_data_q, app_wdf_data_d;
    logic [APP_MASK_WIDTH-1:0] app_wdf_mask_q, app_wdf_mask_d;
    logic [1:0]                lane_q, lane_d;
    logic [1:0]                req_lane;
    logic                      accept;
    logic                      unused_ok;

`ifdef MEM_LINE_CACHE_EN
    logic [APP_DATA_WIDTH-1:0] line_q, line_d;
    logic [27:0]               tag_q, tag_d, fill_tag_q, fill_tag_d;
    logic                      line_valid_q, line_valid_d;
    logic                      hit;
    assign hit = line_valid_q && tag_q == req_addr[31:4];
`endif

    assign req_lane  = req_addr[3:2];
    assign accept    = state_q == IDLE && req_ready_q && req_valid;
    assign unused_ok = ^{req_addr[31:ADDR_WIDTH+1], req_addr[1:0]};

    always_comb begin
        state_d        = state_q;
        resp_valid_d   = 1'b0;
        resp_rdata_d   = resp_rdata_q;
        app_addr_d     = app_addr_q;
        app_cmd_d      = app_cmd_q;
        app_en_d       = app_en_q;
        app_wdf_wren_d = app_wdf_wren_q;
        app_wdf_data_d = app_wdf_data_q;
        app_wdf_mask_d = app_wdf_mask_q;
        lane_d         = lane_q;
`ifdef MEM_LINE_CACHE_EN
        line_d         = line_q;
        tag_d          = tag_q;
        fill_tag_d     = fill_tag_q;
        line_valid_d   = line_valid_q;
`endif
        case (state_q)
            INIT: state_d = init_calib_complete ? IDLE : INIT;
            IDLE: begin
                if (accept) begin
                    lane_d     = req_lane;
                    app_addr_d = {req_addr[ADDR_WIDTH:4], 3'b000};
                    if (req_wren) begin
                        state_d        = WR;
                        app_cmd_d      = CMD_WR;
                        app_en_d       = 1'b1;
                        app_wdf_wren_d = 1'b1;
                        app_wdf_data_d = {(APP_DATA_WIDTH/32){req_wdata}};
                        app_wdf_mask_d = ~(APP_MASK_WIDTH'(4'hF) << {req_lane, 2'b00});
`ifdef MEM_LINE_CACHE_EN
                        if (hit) line_d[{req_lane, 5'd0} +: 32] = req_wdata;
`endif
                    end else if (req_rden) begin
                        state_d   = RD;
                        app_cmd_d = CMD_RD;
                        app_en_d  = 1'b1;
`ifdef MEM_LINE_CACHE_EN
                        fill_tag_d = req_addr[31:4];
                        if (hit) begin
                            state_d      = RESP;
                            app_en_d     = 1'b0;
                            resp_rdata_d = line_q[{req_lane, 5'd0} +: 32];
                        end
`endif
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RD: begin
                if (app_rdy) begin
                    app_en_d = 1'b0;
                    state_d  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (app_rd_data_valid) begin
                    resp_rdata_d = app_rd_data[{lane_q, 5'd0} +: 32];
                    state_d      = RESP;
`ifdef MEM_LINE_CACHE_EN
                    line_d       = app_rd_data;
                    tag_d        = fill_tag_q;
                    line_valid_d = 1'b1;
`endif
                end
            end
            WR: begin
                // command and data strobes retire independently; leave once both are gone
                app_en_d       = app_en_q & ~app_rdy;
                app_wdf_wren_d = app_wdf_wren_q & ~app_wdf_rdy;
                if (!app_en_d && !app_wdf_wren_d) state_d = RESP;
            end
            RESP: begin
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = INIT;
        endcase
        // ready stays low during the response pulse so a still-held request is not re-sampled
        req_ready_d = state_d == IDLE && !resp_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= INIT;
            req_ready_q    <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            app_addr_q     <= '0;
            app_cmd_q      <= CMD_RD;
            app_en_q       <= 1'b0;
            app_wdf_wren_q <= 1'b0;
            app_wdf_data_q <= '0;
            app_wdf_mask_q <= '1;
            lane_q         <= '0;
`ifdef MEM_LINE_CACHE_EN
            line_q         <= '0;
            tag_q          <= '0;
            fill_tag_q     <= '0;
            line_valid_q   <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            app_addr_q     <= app_addr_d;
            app_cmd_q      <= app_cmd_d;
            app_en_q       <= app_en_d;
            app_wdf_wren_q <= app_wdf_wren_d;
            app_wdf_data_q <= app_wdf_data_d;
            app_wdf_mask_q <= app_wdf_mask_d;
            lane_q         <= lane_d;
`ifdef MEM_LINE_CACHE_EN
            line_q         <= line_d;
            tag_q          <= tag_d;
            fill_tag_q     <= fill_tag_d;
            line_valid_q   <= line_valid_d;
`endif
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign app_addr     = app_addr_q;
    assign app_cmd      = app_cmd_q;
    assign app_en       = app_en_q;
    assign app_wdf_wren = app_wdf_wren_q;
    assign app_wdf_data = app_wdf_data_q;
    assign app_wdf_mask = app_wdf_mask_q;
    assign app_wdf_end  = 1'b1;
endmodule

// File: tb/tb_mem_request_bridge.sv
// tb_mem_request_bridge: drives core requests and plays the MIG side against a line-level memory model.
module tb_mem_request_bridge;
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;
`ifdef MEM_LINE_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, init_calib_complete;
    logic         req_valid, req_wren, req_rden;
    logic [31:0]  req_addr, req_wdata;
    logic         req_ready, resp_valid;
    logic [31:0]  resp_rdata;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy, app_rd_data_valid;
    logic [127:0] app_wdf_data, app_rd_data;
    logic [15:0]  app_wdf_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_request_bridge dut (
        .clk(clk), .reset(reset), .init_calib_complete(init_calib_complete),
        .req_valid(req_valid), .req_wren(req_wren), .req_rden(req_rden),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
    );

    // memory contents per 16-byte line, read-buffer shadow and last returned read word
    logic [127:0] mem [int unsigned];
    bit           c_valid;
    int unsigned  c_tag;
    logic [31:0]  exp_rdata;

    function automatic logic [127:0] line_of(input logic [31:0] a);
        int unsigned k = a >> 4;
        return mem.exists(k) ? mem[k] : {a ^ 32'h1111_1111, a ^ 32'h2222_2222, ~a, a ^ 32'h5A5A_5A5A};
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] l, input logic [31:0] a);
        return 32'(l >> (32 * int'(a[3:2])));
    endfunction

    function automatic logic [27:0] exp_addr(input logic [31:0] a);
        return 28'((a >> 4) << 3);
    endfunction

    function automatic logic [15:0] exp_mask(input logic [31:0] a);
        return ~(16'hF << (4 * int'(a[3:2])));
    endfunction

    function automatic bit exp_hit(input logic wr, input logic rd, input logic [31:0] a);
        return CACHE && rd && !wr && c_valid && c_tag == (a >> 4);
    endfunction

    task automatic model_commit(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] wd);
        logic [127:0] l = line_of(a);
        if (wr) begin
            l[32*int'(a[3:2]) +: 32] = wd;
            mem[a >> 4] = l;
        end else if (rd) begin
            exp_rdata = word_of(l, a);
            c_valid = 1'b1;
            c_tag = a >> 4;
        end
    endtask

    // observations of the most recent transaction
    int           o_lat, o_resp, o_en, o_wren, o_ready_bad, o_wait, o_cmd_hs, o_wdf_hs;
    logic [27:0]  o_addr;
    logic [2:0]   o_cmd;
    logic [15:0]  o_mask;
    logic [127:0] o_data;
    logic [31:0]  o_rdata;
    logic         o_after_valid, o_after_ready;

    task automatic run_txn(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] wd,
                           input int rdy_dly, input int wdf_dly, input int rd_dly);
        int hs_c = -1;
        bit rd_sent = 1'b0;
        logic [127:0] line = line_of(a);
        o_lat = -1; o_resp = 0; o_en = 0; o_wren = 0; o_ready_bad = 0; o_wait = 0;
        o_cmd_hs = -1; o_wdf_hs = -1; o_after_valid = 1'bx; o_after_ready = 1'bx;
        while (!req_ready && o_wait < 50) begin
            @(posedge clk); #1;
            o_wait++;
        end
        req_valid = 1'b1; req_wren = wr; req_rden = rd; req_addr = a; req_wdata = wd;
        for (int c = 1; c <= 300 && o_lat < 0; c++) begin
            @(posedge clk); #1;
            app_rd_data_valid = 1'b0;
            if (resp_valid) begin
                o_resp++; o_lat = c; o_rdata = resp_rdata; req_valid = 1'b0;
            end else if (req_ready) o_ready_bad++;
            if (app_en) begin o_en++; o_addr = app_addr; o_cmd = app_cmd; end
            if (app_wdf_wren) begin o_wren++; o_mask = app_wdf_mask; o_data = app_wdf_data; end
            app_rdy = app_en ? (o_en > rdy_dly) : 1'($urandom);
            app_wdf_rdy = app_wdf_wren ? (o_wren > wdf_dly) : 1'($urandom);
            if (app_en && app_rdy) o_cmd_hs = c;
            if (app_wdf_wren && app_wdf_rdy) o_wdf_hs = c;
            if (app_en && app_rdy && app_cmd == CMD_RD) hs_c = c;
            if (hs_c >= 0 && !rd_sent && c >= hs_c + 1 + rd_dly) begin
                app_rd_data_valid = 1'b1; app_rd_data = line; rd_sent = 1'b1;
            end else if (app_en && !app_rdy) begin
                app_rd_data_valid = 1'($urandom); app_rd_data = ~line;
            end
        end
        if (o_lat >= 0) begin
            @(posedge clk); #1;
            o_after_valid = resp_valid; o_after_ready = req_ready;
        end
        req_valid = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; init_calib_complete = 1'b0;
        for (int i = 0; i < 3; i++) begin
            app_rd_data_valid = 1'b1; app_rd_data = {4{32'hDEAD_BEEF}};
            @(posedge clk); #1;
            checks++;
            if ({app_en, app_wdf_wren, req_ready, resp_valid} !== 4'b0) begin
                errors++; $display("FAIL reset_strobes: got %b expected 0000", {app_en, app_wdf_wren, req_ready, resp_valid});
            end
        end
        checks++;
        if (app_cmd !== CMD_RD || app_addr !== 28'h0 || app_wdf_mask !== 16'hFFFF) begin
            errors++; $display("FAIL reset_app: got cmd=%b addr=%h mask=%h expected 001/0/ffff", app_cmd, app_addr, app_wdf_mask);
        end
        checks++;
        if (app_wdf_data !== 128'h0 || resp_rdata !== 32'h0 || app_wdf_end !== 1'b1) begin
            errors++; $display("FAIL reset_data: got wdf=%h rdata=%h end=%b expected 0/0/1", app_wdf_data, resp_rdata, app_wdf_end);
        end
        reset = 1'b0;
        app_rd_data_valid = 1'b1;
        @(posedge clk); #1;
        app_rd_data_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL uncalibrated_ready: got ready=%b resp=%b expected 0/0", req_ready, resp_valid);
        end
        init_calib_complete = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL calib_ready: got %b expected 1", req_ready);
        end
        c_valid = 1'b0; exp_rdata = 32'h0;
    endtask

    task automatic test_write_basic();
        run_txn(1'b1, 1'b0, 32'h0000_0048, 32'hCAFE_F00D, 0, 0, 0);
        checks++;
        if (o_addr !== 28'h20 || o_cmd !== CMD_WR) begin
            errors++; $display("FAIL wr_addr_cmd: got addr=%h cmd=%b expected 20/000", o_addr, o_cmd);
        end
        checks++;
        if (o_mask !== 16'hF0FF || o_data !== {4{32'hCAFE_F00D}}) begin
            errors++; $display("FAIL wr_mask_data: got mask=%h data=%h expected f0ff/%h", o_mask, o_data, {4{32'hCAFE_F00D}});
        end
        checks++;
        if (o_resp !== 1 || o_lat !== 3 || o_en !== 1 || o_wren !== 1) begin
            errors++; $display("FAIL wr_timing: got resp=%0d lat=%0d en=%0d wren=%0d expected 1/3/1/1", o_resp, o_lat, o_en, o_wren);
        end
        checks++;
        if (o_after_valid !== 1'b0 || o_after_ready !== 1'b1 || o_ready_bad !== 0) begin
            errors++; $display("FAIL wr_handoff: got after_valid=%b after_ready=%b busy_ready=%0d expected 0/1/0", o_after_valid, o_after_ready, o_ready_bad);
        end
        model_commit(1'b1, 1'b0, 32'h0000_0048, 32'hCAFE_F00D);
    endtask

    task automatic test_read_stall();
        mem[32'h14 >> 4] = {32'hBEADBEAD, 32'hBABEBABE, 32'hFACEFACE, 32'hCAFECAFE};
        run_txn(1'b0, 1'b1, 32'h0000_0014, 32'h0, 5, 0, 0);
        checks++;
        if (o_en !== 6 || o_addr !== 28'h8 || o_cmd !== CMD_RD) begin
            errors++; $display("FAIL rd_stall_cmd: got en=%0d addr=%h cmd=%b expected 6/8/001", o_en, o_addr, o_cmd);
        end
        checks++;
        if (o_rdata !== 32'hFACEFACE || o_resp !== 1 || o_lat !== 9) begin
            errors++; $display("FAIL rd_stall_resp: got rdata=%h resp=%0d lat=%0d expected facefSace/1/9", o_rdata, o_resp, o_lat);
        end
        model_commit(1'b0, 1'b1, 32'h0000_0014, 32'h0);
    endtask

    task automatic test_write_split();
        run_txn(1'b1, 1'b0, 32'h0000_002C, 32'h1234_5678, 0, 3, 0);
        checks++;
        if (o_en !== 1 || o_wren !== 4 || o_cmd_hs >= o_wdf_hs) begin
            errors++; $display("FAIL wr_data_late: got en=%0d wren=%0d cmd_hs=%0d wdf_hs=%0d expected 1/4/earlier", o_en, o_wren, o_cmd_hs, o_wdf_hs);
        end
        checks++;
        if (o_resp !== 1 || o_lat !== 6 || o_mask !== 16'h0FFF) begin
            errors++; $display("FAIL wr_data_late_resp: got resp=%0d lat=%0d mask=%h expected 1/6/0fff", o_resp, o_lat, o_mask);
        end
        model_commit(1'b1, 1'b0, 32'h0000_002C, 32'h1234_5678);
        run_txn(1'b1, 1'b0, 32'h0000_0030, 32'h8765_4321, 2, 0, 0);
        checks++;
        if (o_en !== 3 || o_wren !== 1 || o_lat !== 5 || o_resp !== 1) begin
            errors++; $display("FAIL wr_data_early: got en=%0d wren=%0d lat=%0d resp=%0d expected 3/1/5/1", o_en, o_wren, o_lat, o_resp);
        end
        model_commit(1'b1, 1'b0, 32'h0000_0030, 32'h8765_4321);
    endtask

    task automatic test_noop();
        run_txn(1'b0, 1'b0, 32'h0000_0200, 32'hFFFF_FFFF, 0, 0, 0);
        checks++;
        if (o_lat !== 2 || o_resp !== 1 || o_en !== 0 || o_wren !== 0) begin
            errors++; $display("FAIL noop: got lat=%0d resp=%0d en=%0d wren=%0d expected 2/1/0/0", o_lat, o_resp, o_en, o_wren);
        end
        checks++;
        if (o_rdata !== exp_rdata) begin
            errors++; $display("FAIL noop_rdata_hold: got %h expected %h", o_rdata, exp_rdata);
        end
        run_txn(1'b1, 1'b1, 32'h0000_0044, 32'hA5A5_0001, 1, 1, 0);
        checks++;
        if (o_cmd !== CMD_WR || o_wren !== 2 || o_rdata !== exp_rdata) begin
            errors++; $display("FAIL both_is_write: got cmd=%b wren=%0d rdata=%h expected 000/2/%h", o_cmd, o_wren, o_rdata, exp_rdata);
        end
        model_commit(1'b1, 1'b1, 32'h0000_0044, 32'hA5A5_0001);
    endtask

    task automatic test_line_reuse();
        logic [31:0] seq_a [4] = '{32'h100, 32'h104, 32'h108, 32'h108};
        logic        seq_w [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            bit h = exp_hit(seq_w[i], !seq_w[i], seq_a[i]);
            logic [31:0] wd = 32'h0BAD_0000 + 32'(i);
            logic [31:0] ew = word_of(line_of(seq_a[i]), seq_a[i]);
            run_txn(seq_w[i], !seq_w[i], seq_a[i], wd, 1, 0, 1);
            checks++;
            if (o_en !== (h ? 0 : 2) || o_lat !== (seq_w[i] ? 4 : h ? 2 : 6)) begin
                errors++; $display("FAIL line_reuse_%0d: got en=%0d lat=%0d expected %0d/%0d", i, o_en, o_lat, h ? 0 : 2, seq_w[i] ? 4 : h ? 2 : 6);
            end
            if (!seq_w[i]) begin
                checks++;
                if (o_rdata !== ew) begin
                    errors++; $display("FAIL line_reuse_data_%0d: got %h expected %h", i, o_rdata, ew);
                end
            end
            model_commit(seq_w[i], !seq_w[i], seq_a[i], wd);
        end
    endtask

    task automatic test_reset_rd_wait();
        int n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        req_valid = 1'b1; req_wren = 1'b0; req_rden = 1'b1; req_addr = 32'h0BAD_0F00;
        n = 0;
        while (!app_en && n < 10) begin @(posedge clk); #1; n++; end
        checks++;
        if (app_en !== 1'b1) begin
            errors++; $display("FAIL abort_setup: got app_en=%b expected 1", app_en);
        end
        app_rdy = 1'b1;
        @(posedge clk); #1;
        app_rdy = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        app_rd_data_valid = 1'b1; app_rd_data = {4{32'h5555_AAAA}};
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0 || app_en !== 1'b0) begin
            errors++; $display("FAIL abort_in_reset: got resp=%b ready=%b en=%b expected 0/0/0", resp_valid, req_ready, app_en);
        end
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            app_rd_data_valid = 1'b0;
            n += int'(resp_valid);
        end
        checks++;
        if (n !== 0 || req_ready !== 1'b1 || resp_rdata !== 32'h0) begin
            errors++; $display("FAIL abort_no_resp: got pulses=%0d ready=%b rdata=%h expected 0/1/0", n, req_ready, resp_rdata);
        end
        c_valid = 1'b0; exp_rdata = 32'h0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int op = $urandom_range(0, 9);
            logic wr = op >= 1 && op <= 5;
            logic rd = op == 1 || op >= 6;
            logic [31:0] a = 32'h0000_1000 + 32'($urandom_range(0, 2) << 4) + 32'($urandom_range(0, 15));
            logic [31:0] wd = $urandom;
            int rdy = $urandom_range(0, 3), wdf = $urandom_range(0, 3), rdd = $urandom_range(0, 3);
            bit h = exp_hit(wr, rd, a);
            bit mr = rd && !wr && !h;
            int el = wr ? (rdy > wdf ? rdy : wdf) + 3 : mr ? rdy + rdd + 4 : 2;
            logic [31:0] ew = (rd && !wr) ? word_of(line_of(a), a) : exp_rdata;
            init_calib_complete = 1'($urandom);
            run_txn(wr, rd, a, wd, rdy, wdf, rdd);
            checks++;
            if (o_lat !== el || o_resp !== 1) begin
                errors++; $display("FAIL rand_lat_%0d: got lat=%0d resp=%0d expected %0d/1", i, o_lat, o_resp, el);
            end
            checks++;
            if (o_en !== ((wr || mr) ? rdy + 1 : 0) || o_wren !== (wr ? wdf + 1 : 0)) begin
                errors++; $display("FAIL rand_strobes_%0d: got en=%0d wren=%0d expected %0d/%0d", i, o_en, o_wren, (wr || mr) ? rdy + 1 : 0, wr ? wdf + 1 : 0);
            end
            if (wr || mr) begin
                checks++;
                if (o_addr !== exp_addr(a) || o_cmd !== (wr ? CMD_WR : CMD_RD)) begin
                    errors++; $display("FAIL rand_cmd_%0d: got addr=%h cmd=%b expected %h/%b", i, o_addr, o_cmd, exp_addr(a), wr ? CMD_WR : CMD_RD);
                end
            end
            if (wr) begin
                checks++;
                if (o_mask !== exp_mask(a) || o_data !== {4{wd}}) begin
                    errors++; $display("FAIL rand_wdata_%0d: got mask=%h data=%h expected %h/%h", i, o_mask, o_data, exp_mask(a), {4{wd}});
                end
            end
            checks++;
            if (o_rdata !== ew) begin
                errors++; $display("FAIL rand_rdata_%0d: got %h expected %h", i, o_rdata, ew);
            end
            checks++;
            if (o_after_valid !== 1'b0 || o_after_ready !== 1'b1 || o_ready_bad !== 0) begin
                errors++; $display("FAIL rand_back_to_back_%0d: got after_valid=%b after_ready=%b busy_ready=%0d expected 0/1/0", i, o_after_valid, o_after_ready, o_ready_bad);
            end
            model_commit(wr, rd, a, wd);
        end
        init_calib_complete = 1'b1;
    endtask

    initial begin
        reset = 1'b1; init_calib_complete = 1'b0;
        req_valid = 1'b0; req_wren = 1'b0; req_rden = 1'b0; req_addr = '0; req_wdata = '0;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data_valid = 1'b0; app_rd_data = '0;
        c_valid = 1'b0; c_tag = 0; exp_rdata = 32'h0;
        test_reset();
        test_write_basic();
        test_read_stall();
        test_write_split();
        test_noop();
        test_line_reuse();
        test_reset_rd_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
